pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 136 +++++++++++++
 tb/tb_pc_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch program-counter generator: exception/eret/redirect sequencing, a
// one-deep redirect buffer for stalled cycles, and a small return-address stack.
module pc_gen #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_PC    = 32'h0000_4180,
    parameter logic [WIDTH-1:0] IM_BASE   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IM_LIMIT  = 32'h0000_6FFC,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_pc,
    input  logic             ras_push,
    input  logic [WIDTH-1:0] ras_push_addr,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             adel_f,
    output logic             redir_pending,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_valid
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    // ------------------------------------------------------------------
    // PC sequencing
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;

    assign pc_f          = pc_q;
    assign pc_plus4      = pc_q + WIDTH'(4);
    assign redir_pending = pend_q;
    assign adel_f        = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the if/else chain leaves a signal unassigned (no latch).
        pc_d      = pc_plus4;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;

        if (req) begin
            pc_d   = EXC_PC;
            pend_d = 1'b0;
        end else if (eret) begin
            pc_d   = epc;
            pend_d = 1'b0;
        end else if (redir_valid && !stall) begin
            pc_d   = redir_pc;
            pend_d = 1'b0;
        end else if (redir_valid) begin
            // Stalled redirect: remember the newest target, fetch holds.
            pc_d      = pc_q;
            pend_d    = 1'b1;
            pend_pc_d = redir_pc;
        end else if (pend_q && !stall) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Return-address stack (circular, oldest entry overwritten when full)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q;
    logic [CNT_W-1:0] ras_cnt_q;
    logic [PTR_W-1:0] top_idx, wr_idx;
    logic             ras_en, ras_empty, ras_full;
    logic             do_push, do_pop, do_replace;

    assign ras_en     = !stall && !req && !eret;
    assign ras_empty  = (ras_cnt_q == '0);
    assign ras_full   = (ras_cnt_q == CNT_W'(RAS_DEPTH));
    assign top_idx    = ras_ptr_q - PTR_W'(1);

    assign do_push    = ras_en && ras_push && (!ras_pop || ras_empty);
    assign do_replace = ras_en && ras_push && ras_pop && !ras_empty;
    assign do_pop     = ras_en && ras_pop && !ras_push && !ras_empty;
    assign wr_idx     = do_replace ? top_idx : ras_ptr_q;

    assign ras_valid  = !ras_empty;
    assign ras_top    = ras_empty ? '0 : ras_mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (req) begin
            ras_cnt_q <= '0;
        end else if (do_push) begin
            ras_ptr_q <= ras_ptr_q + PTR_W'(1);
            if (!ras_full) begin
                ras_cnt_q <= ras_cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            ras_ptr_q <= top_idx;
            ras_cnt_q <= ras_cnt_q - CNT_W'(1);
        end
    end

    // NOTE: the entry array has no reset; the count gates every read, so
    // stale contents are never visible and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && (do_push || do_replace)) begin
            ras_mem[wr_idx] <= ras_push_addr;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected state is queued per driven step and
// compared against the DUT one clock later.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, req, eret, stall, redir_valid, ras_push, ras_pop;
    logic [31:0] epc, redir_pc, ras_push_addr;
    logic [31:0] pc_f, pc_plus4, ras_top;
    logic        adel_f, redir_pending, ras_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        pend;
        logic        rv;
        logic [31:0] top;
    } exp_t;

    exp_t sb[$];

    pc_gen dut (
        .clk(clk), .reset(reset), .req(req), .eret(eret), .epc(epc),
        .stall(stall), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
        .pc_f(pc_f), .pc_plus4(pc_plus4), .adel_f(adel_f),
        .redir_pending(redir_pending), .ras_top(ras_top), .ras_valid(ras_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reset = 0; req = 0; eret = 0; stall = 0; redir_valid = 0;
        ras_push = 0; ras_pop = 0;
        epc = '0; redir_pc = '0; ras_push_addr = '0;
    endtask

    // Queue the expected post-edge state, clock once, compare, release inputs.
    task automatic cycle(input string tag, input logic [31:0] pc, input logic pend,
                         input logic rv, input logic [31:0] top);
        exp_t e;
        logic exp_adel;
        sb.push_back('{tag, pc, pend, rv, top});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        exp_adel = (e.pc[1:0] != 2'b00) || (e.pc < 32'h3000) || (e.pc > 32'h6FFC);
        check({e.tag, ".pc_f"},          pc_f,                   e.pc);
        check({e.tag, ".pc_plus4"},      pc_plus4,               e.pc + 32'd4);
        check({e.tag, ".adel_f"},        {31'b0, adel_f},        {31'b0, exp_adel});
        check({e.tag, ".redir_pending"}, {31'b0, redir_pending}, {31'b0, e.pend});
        check({e.tag, ".ras_valid"},     {31'b0, ras_valid},     {31'b0, e.rv});
        check({e.tag, ".ras_top"},       ras_top,                e.top);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        #1;

        // Reset and free-running fetch
        reset = 1;                                        cycle("reset",  32'h3000, 0, 0, 0);
                                                          cycle("seq1",   32'h3004, 0, 0, 0);
                                                          cycle("seq2",   32'h3008, 0, 0, 0);
                                                          cycle("seq3",   32'h300C, 0, 0, 0);

        // Redirects arriving during stall; newest wins
        stall = 1; redir_valid = 1; redir_pc = 32'h3100;  cycle("stl_rd1", 32'h300C, 1, 0, 0);
        stall = 1; redir_valid = 1; redir_pc = 32'h3200;  cycle("stl_rd2", 32'h300C, 1, 0, 0);
        stall = 1;                                        cycle("stl_hold", 32'h300C, 1, 0, 0);
                                                          cycle("pend_go", 32'h3200, 0, 0, 0);
                                                          cycle("seq4",   32'h3204, 0, 0, 0);

        // req beats stall and redirect, drops pending and empties the RAS
        ras_push = 1; ras_push_addr = 32'h3208;           cycle("push0",  32'h3208, 0, 1, 32'h3208);
        stall = 1; redir_valid = 1; redir_pc = 32'h3300;  cycle("stl_rd3", 32'h3208, 1, 1, 32'h3208);
        req = 1; stall = 1; redir_valid = 1; redir_pc = 32'h3400;
                                                          cycle("req",    32'h4180, 0, 0, 0);
        eret = 1; epc = 32'h3010; stall = 1;              cycle("eret",   32'h3010, 0, 0, 0);
                                                          cycle("seq5",   32'h3014, 0, 0, 0);

        // RAS fill past depth, then drain
        ras_push = 1; ras_push_addr = 32'h3004;           cycle("push1",  32'h3018, 0, 1, 32'h3004);
        ras_push = 1; ras_push_addr = 32'h3008;           cycle("push2",  32'h301C, 0, 1, 32'h3008);
        ras_push = 1; ras_push_addr = 32'h300C;           cycle("push3",  32'h3020, 0, 1, 32'h300C);
        ras_push = 1; ras_push_addr = 32'h3010;           cycle("push4",  32'h3024, 0, 1, 32'h3010);
        ras_push = 1; ras_push_addr = 32'h3014;           cycle("push5",  32'h3028, 0, 1, 32'h3014);
        eret = 1; epc = 32'h3030; ras_pop = 1;            cycle("eret_pop", 32'h3030, 0, 1, 32'h3014);
        stall = 1; ras_pop = 1;                           cycle("stl_pop", 32'h3030, 0, 1, 32'h3014);
        ras_pop = 1;                                      cycle("pop1",   32'h3034, 0, 1, 32'h3010);
        ras_pop = 1;                                      cycle("pop2",   32'h3038, 0, 1, 32'h300C);
        ras_pop = 1;                                      cycle("pop3",   32'h303C, 0, 1, 32'h3008);
        ras_pop = 1;                                      cycle("pop4",   32'h3040, 0, 0, 0);
        ras_pop = 1;                                      cycle("pop5",   32'h3044, 0, 0, 0);

        // Simultaneous push/pop replaces the top; on empty it is a push
        ras_push = 1; ras_push_addr = 32'h3040;           cycle("pushA",  32'h3048, 0, 1, 32'h3040);
        ras_push = 1; ras_push_addr = 32'h3044;           cycle("pushB",  32'h304C, 0, 1, 32'h3044);
        ras_push = 1; ras_pop = 1; ras_push_addr = 32'h3050;
                                                          cycle("pushpop", 32'h3050, 0, 1, 32'h3050);
        ras_pop = 1;                                      cycle("popA",   32'h3054, 0, 1, 32'h3040);
        ras_pop = 1;                                      cycle("popB",   32'h3058, 0, 0, 0);
        ras_push = 1; ras_pop = 1; ras_push_addr = 32'h3060;
                                                          cycle("pp_empty", 32'h305C, 0, 1, 32'h3060);
        ras_pop = 1;                                      cycle("popC",   32'h3060, 0, 0, 0);

        // Fetch address errors and limit boundaries
        redir_valid = 1; redir_pc = 32'h3002;             cycle("unalign", 32'h3002, 0, 0, 0);
                                                          cycle("unal_seq", 32'h3006, 0, 0, 0);
        redir_valid = 1; redir_pc = 32'h2FFC;             cycle("below",  32'h2FFC, 0, 0, 0);
                                                          cycle("base",   32'h3000, 0, 0, 0);
        redir_valid = 1; redir_pc = 32'h7000;             cycle("above",  32'h7000, 0, 0, 0);
                                                          cycle("abv_seq", 32'h7004, 0, 0, 0);
        redir_valid = 1; redir_pc = 32'h6FFC;             cycle("limit",  32'h6FFC, 0, 0, 0);
                                                          cycle("lim_seq", 32'h7000, 0, 0, 0);
        redir_valid = 1; redir_pc = 32'hFFFF_FFFC;        cycle("top",    32'hFFFF_FFFC, 0, 0, 0);
                                                          cycle("wrap",   32'h0000_0000, 0, 0, 0);

        // Reset overrides everything, including a stalled pending redirect
        ras_push = 1; ras_push_addr = 32'h1234;           cycle("pushR",  32'h0004, 0, 1, 32'h1234);
        stall = 1; redir_valid = 1; redir_pc = 32'h3100;  cycle("stl_rd4", 32'h0004, 1, 1, 32'h1234);
        reset = 1; req = 1; eret = 1; epc = 32'h3010; stall = 1;
        redir_valid = 1; redir_pc = 32'h3500; ras_push = 1; ras_push_addr = 32'h5555;
                                                          cycle("reset2", 32'h3000, 0, 0, 0);
                                                          cycle("post_rst", 32'h3004, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
